// File: rtl/rle_decode.sv
// Run-length decoder: reads (count, value) byte pairs over DPSRAM port A, expands
// them, packs bytes little-endian into 32-bit words and writes them to out_addr.
module rle_decode #(
    parameter int ADDR_W  = 16,
    parameter int MAX_OUT = 16383
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              start,
    input  logic [31:0]       rle_addr,
    input  logic [31:0]       rle_size,
    input  logic [31:0]       out_addr,
    output logic [31:0]       out_size,
    output logic              done,
    output logic              port_A_clk,
    output logic [31:0]       port_A_data_in,
    input  logic [31:0]       port_A_data_out,
    output logic [ADDR_W-1:0] port_A_addr,
    output logic              port_A_we
);

    typedef enum logic [2:0] {IDLE, READ, WAIT, EXPAND, WRITE, FLUSH, DONE} state_t;

    localparam logic [31:0]       MAX_OUT_W = 32'(MAX_OUT);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

    state_t            state_q, ret_q;
    logic [ADDR_W-1:0] rd_addr_q, wr_addr_q, addr_q;
    logic [30:0]       pairs_left_q;
    logic [23:0]       word_q;      // bytes 1..3 of the fetched word; byte 0 goes to run_q
    logic [7:0]        run_q;
    logic              pair_sel_q;
    logic [31:0]       pack_q, data_q, out_size_q;
    logic              done_q, we_q;

    logic [1:0]        lane;
    logic              emit, pair_end, word_end, full;
    logic [7:0]        cur_val;
    logic [31:0]       out_size_d, pack_d;
    logic [30:0]       pairs_left_d;
    state_t            after_d;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        lane         = out_size_q[1:0];
        emit         = (run_q != 8'd0);
        cur_val      = pair_sel_q ? word_q[23:16] : word_q[7:0];
        out_size_d   = out_size_q + {31'd0, emit};
        pack_d       = pack_q;
        if (emit) begin
            pack_d[{lane, 3'b000} +: 8] = cur_val;
        end
        pair_end     = (run_q <= 8'd1);
        pairs_left_d = pairs_left_q - {30'd0, pair_end};
        word_end     = pair_end && (pair_sel_q || pairs_left_d == '0);
        full         = emit && (lane == 2'd3);
        if (out_size_d == MAX_OUT_W || (word_end && pairs_left_d == '0)) begin
            after_d = FLUSH;
        end else if (word_end) begin
            after_d = READ;
        end else begin
            after_d = EXPAND;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= IDLE;
            ret_q        <= IDLE;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            addr_q       <= '0;
            pairs_left_q <= '0;
            word_q       <= '0;
            run_q        <= '0;
            pair_sel_q   <= 1'b0;
            pack_q       <= '0;
            data_q       <= '0;
            out_size_q   <= '0;
            done_q       <= 1'b0;
            we_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        rd_addr_q    <= rle_addr[ADDR_W-1:0];
                        addr_q       <= rle_addr[ADDR_W-1:0];
                        wr_addr_q    <= out_addr[ADDR_W-1:0];
                        pairs_left_q <= rle_size[31:1];
                        out_size_q   <= '0;
                        pack_q       <= '0;
                        if (rle_size[31:1] == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= READ;
                            done_q  <= 1'b0;
                        end
                    end
                end
                READ: begin
                    rd_addr_q <= rd_addr_q + WORD_STEP;
                    state_q   <= WAIT;
                end
                WAIT: begin
                    word_q     <= port_A_data_out[31:8];
                    run_q      <= port_A_data_out[7:0];
                    pair_sel_q <= 1'b0;
                    state_q    <= EXPAND;
                end
                EXPAND: begin
                    out_size_q   <= out_size_d;
                    pairs_left_q <= pairs_left_d;
                    if (pair_end) begin
                        pair_sel_q <= 1'b1;
                        run_q      <= word_q[15:8];
                    end else begin
                        run_q <= run_q - 8'd1;
                    end
                    if (full) begin
                        pack_q  <= '0;
                        data_q  <= pack_d;
                        addr_q  <= wr_addr_q;
                        we_q    <= 1'b1;
                        ret_q   <= after_d;
                        state_q <= WRITE;
                    end else begin
                        pack_q  <= pack_d;
                        state_q <= after_d;
                        if (after_d == READ) begin
                            addr_q <= rd_addr_q;
                        end
                        if (after_d == FLUSH) begin
                            data_q <= pack_d;
                            addr_q <= wr_addr_q;
                            we_q   <= (out_size_d[1:0] != 2'd0);
                        end
                    end
                end
                WRITE: begin
                    we_q      <= 1'b0;
                    wr_addr_q <= wr_addr_q + WORD_STEP;
                    state_q   <= ret_q;
                    if (ret_q == READ) begin
                        addr_q <= rd_addr_q;
                    end
                end
                FLUSH: begin
                    we_q    <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{rle_addr[31:ADDR_W], out_addr[31:ADDR_W], rle_size[0]};

    assign port_A_clk     = clk;
    assign port_A_addr    = addr_q;
    assign port_A_data_in = data_q;
    assign port_A_we      = we_q;
    assign out_size       = out_size_q;
    assign done           = done_q;

endmodule

// File: tb/tb_rle_decode.sv
// Directed bench for rle_decode: behavioural port-A memory, write monitor,
// reference expansion model and hand-computed expected words.
module tb_rle_decode;

    localparam int ADDR_W  = 16;
    localparam int MAX_OUT = 16383;

    logic              clk = 1'b0;
    logic              nreset, start;
    logic [31:0]       rle_addr, rle_size, out_addr, out_size;
    logic              done, port_A_clk, port_A_we;
    logic [31:0]       port_A_data_in, port_A_data_out;
    logic [ADDR_W-1:0] port_A_addr;

    always #5 clk = ~clk;

    rle_decode #(.ADDR_W(ADDR_W), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .nreset(nreset), .start(start),
        .rle_addr(rle_addr), .rle_size(rle_size), .out_addr(out_addr),
        .out_size(out_size), .done(done), .port_A_clk(port_A_clk),
        .port_A_data_in(port_A_data_in), .port_A_data_out(port_A_data_out),
        .port_A_addr(port_A_addr), .port_A_we(port_A_we)
    );

    // Port-A memory: one-cycle read latency; the bench preloads through ld_*.
    logic [31:0]       mem [0:(1<<(ADDR_W-2))-1];
    logic              ld_en;
    logic [ADDR_W-3:0] ld_idx;
    logic [31:0]       ld_data;

    always @(posedge clk) begin
        if (ld_en) mem[ld_idx] <= ld_data;
        else if (port_A_we) mem[port_A_addr[ADDR_W-1:2]] <= port_A_data_in;
        port_A_data_out <= mem[port_A_addr[ADDR_W-1:2]];
    end

    logic [ADDR_W-1:0] wr_a_q[$];
    logic [31:0]       wr_d_q[$];
    int                misaligned;

    always @(negedge clk) begin
        if (port_A_addr[1:0] != 2'b00) misaligned++;
        if (port_A_we) begin
            wr_a_q.push_back(port_A_addr);
            wr_d_q.push_back(port_A_data_in);
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    logic [7:0]        strm[$];
    logic [31:0]       exp_d[$];
    logic [ADDR_W-1:0] exp_a[$];
    int                exp_n;
    logic [31:0]       plain [12] = '{32'hAAAAAAAA, 32'hAAAAAAAA, 32'hBBBBAAAA, 32'hBBBBBBBB,
                                      32'hCCCCCCCC, 32'hCCCCCCCC, 32'hCCCCCCCC, 32'hCCCCCCCC,
                                      32'hDDDDDDDD, 32'hEEEEEEEE, 32'hEEEEEEEE, 32'h11111111};

    task automatic load_stream(input logic [31:0] base);
        logic [31:0] w;
        for (int i = 0; i * 4 < strm.size(); i++) begin
            w = '0;
            for (int b = 0; b < 4; b++)
                if (i * 4 + b < strm.size()) w[8*b +: 8] = strm[i*4 + b];
            @(negedge clk);
            ld_en   = 1'b1;
            ld_idx  = base[ADDR_W-1:2] + (ADDR_W-2)'(i);
            ld_data = w;
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Reference expansion of strm into the expected write sequence.
    task automatic model(input int size, input logic [31:0] oaddr);
        logic [7:0]  bytes[$];
        logic [31:0] d;
        exp_d.delete();
        exp_a.delete();
        for (int j = 0; j < size / 2; j++)
            for (int k = 0; k < int'(strm[2*j]); k++)
                if (bytes.size() < MAX_OUT) bytes.push_back(strm[2*j + 1]);
        exp_n = bytes.size();
        for (int w = 0; w * 4 < exp_n; w++) begin
            d = '0;
            for (int b = 0; b < 4; b++)
                if (w * 4 + b < exp_n) d[8*b +: 8] = bytes[w*4 + b];
            exp_d.push_back(d);
            exp_a.push_back(ADDR_W'(oaddr + 32'(4 * w)));
        end
    endtask

    task automatic run(input logic [31:0] ra, input logic [31:0] rs, input logic [31:0] oa,
                       input int budget, output int cycles);
        @(negedge clk);
        wr_a_q.delete();
        wr_d_q.delete();
        misaligned = 0;
        rle_addr = ra;
        rle_size = rs;
        out_addr = oa;
        start    = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cycles = 1;
        while (!done && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        check("done_within_budget", {31'd0, done}, 32'd1);
    endtask

    task automatic compare(input string tag);
        int n;
        check({tag, "_nwr"}, 32'(wr_d_q.size()), 32'(exp_d.size()));
        check({tag, "_out_size"}, out_size, 32'(exp_n));
        check({tag, "_align"}, 32'(misaligned), 32'd0);
        n = (wr_d_q.size() < exp_d.size()) ? wr_d_q.size() : exp_d.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(wr_a_q[i]), 32'(exp_a[i]));
            check($sformatf("%s_data%0d", tag, i), wr_d_q[i], exp_d[i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, n0;
        nreset = 1'b0; start = 1'b0; ld_en = 1'b0; ld_idx = '0; ld_data = '0;
        rle_addr = '0; rle_size = '0; out_addr = '0; misaligned = 0;
        repeat (3) @(negedge clk);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_out_size", out_size, 32'd0);
        check("rst_we", {31'd0, port_A_we}, 32'd0);
        check("rst_addr", 32'(port_A_addr), 32'd0);
        check("rst_data", port_A_data_in, 32'd0);
        nreset = 1'b1;

        // Basic two-pair word.
        strm = '{8'h04, 8'h41, 8'h02, 8'h42};
        load_stream(32'hC8);
        model(4, 32'h200);
        run(32'hC8, 32'd4, 32'h200, 100, cyc);
        check("t1_w0", wr_d_q[0], 32'h41414141);
        check("t1_a0", 32'(wr_a_q[0]), 32'h200);
        check("t1_w1", wr_d_q[1], 32'h00004242);
        check("t1_a1", 32'(wr_a_q[1]), 32'h204);
        check("t1_size", out_size, 32'd6);
        check("t1_latency", 32'(cyc), 32'd11);
        compare("t1");
        repeat (5) @(negedge clk);
        check("t1_done_held", {31'd0, done}, 32'd1);
        check("t1_idle_we", {31'd0, port_A_we}, 32'd0);

        // Count-0 pair, then a 255-byte run crossing many words.
        strm = '{8'h00, 8'h77, 8'h03, 8'hFF, 8'h01, 8'h11, 8'hFF, 8'h10};
        load_stream(32'h300);
        model(8, 32'h1000);
        run(32'h300, 32'd8, 32'h1000, 1000, cyc);
        check("t2_size", out_size, 32'd259);
        check("t2_nwr", 32'(wr_d_q.size()), 32'd65);
        check("t2_w0", wr_d_q[0], 32'h11FFFFFF);
        check("t2_w1", wr_d_q[1], 32'h10101010);
        check("t2_wlast", wr_d_q[64], 32'h00101010);
        check("t2_alast", 32'(wr_a_q[64]), 32'h1100);
        compare("t2");

        // Empty stream.
        run(32'h300, 32'd0, 32'h1000, 20, cyc);
        check("t3_fast", {31'd0, cyc <= 2}, 32'd1);
        check("t3_nwr", 32'(wr_d_q.size()), 32'd0);
        check("t3_size", out_size, 32'd0);

        // Odd length: the trailing byte would be a huge run if it were decoded.
        strm = '{8'h04, 8'h41, 8'h02, 8'h42, 8'h7F, 8'h10};
        load_stream(32'h400);
        model(5, 32'h500);
        run(32'h400, 32'd5, 32'h500, 200, cyc);
        check("t4_nwr", 32'(wr_d_q.size()), 32'd2);
        check("t4_w0", wr_d_q[0], 32'h41414141);
        check("t4_w1", wr_d_q[1], 32'h00004242);
        check("t4_size", out_size, 32'd6);
        compare("t4");

        // Destination wraps past the top of the address space.
        strm = '{8'h04, 8'h41, 8'h02, 8'h42};
        load_stream(32'h100);
        model(4, 32'hFFFC);
        run(32'h100, 32'd4, 32'hFFFC, 100, cyc);
        check("wrap_a0", 32'(wr_a_q[0]), 32'hFFFC);
        check("wrap_a1", 32'(wr_a_q[1]), 32'h0000);
        compare("wrap");

        // Reset in the middle of a long run.
        strm = '{8'hFF, 8'h55};
        load_stream(32'h600);
        @(negedge clk);
        rle_addr = 32'h600; rle_size = 32'd2; out_addr = 32'h2000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        nreset = 1'b0;
        #1;
        check("t5_done", {31'd0, done}, 32'd0);
        check("t5_size", out_size, 32'd0);
        check("t5_we", {31'd0, port_A_we}, 32'd0);
        check("t5_addr", 32'(port_A_addr), 32'd0);
        check("t5_data", port_A_data_in, 32'd0);
        n0 = wr_d_q.size();
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        repeat (20) @(negedge clk);
        check("t5_no_writes", 32'(wr_d_q.size()), 32'(n0));
        check("t5_idle", {31'd0, done}, 32'd0);
        strm = '{8'h04, 8'h41, 8'h02, 8'h42};
        load_stream(32'h700);
        model(4, 32'h800);
        run(32'h700, 32'd4, 32'h800, 100, cyc);
        compare("t5_restart");

        // Round trip of a 48-byte frame from its 12-byte compressed form.
        strm = '{8'h0A, 8'hAA, 8'h06, 8'hBB, 8'h10, 8'hCC,
                 8'h04, 8'hDD, 8'h08, 8'hEE, 8'h04, 8'h11};
        load_stream(32'h900);
        run(32'h900, 32'd12, 32'hA00, 500, cyc);
        check("t6_size", out_size, 32'd48);
        check("t6_nwr", 32'(wr_d_q.size()), 32'd12);
        check("t6_align", 32'(misaligned), 32'd0);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("t6_word%0d", i), wr_d_q[i], plain[i]);
            check($sformatf("t6_addr%0d", i), 32'(wr_a_q[i]), 32'hA00 + 32'(4 * i));
        end

        // Output cap: 66 runs of 255 would give 16830 bytes.
        strm.delete();
        for (int j = 0; j < 66; j++) begin
            strm.push_back(8'hFF);
            strm.push_back(8'(j + 1));
        end
        load_stream(32'h0);
        model(132, 32'h4000);
        run(32'h0, 32'd132, 32'h4000, 30000, cyc);
        check("max_size", out_size, 32'd16383);
        check("max_nwr", 32'(wr_d_q.size()), 32'd4096);
        check("max_wlast", wr_d_q[4095], 32'h00414141);
        check("max_alast", 32'(wr_a_q[4095]), 32'h7FFC);
        compare("max");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
